// File: rtl/finn_rtl_krnl_read_seq_pkg.sv
// Shared types and helpers for the kernel AXI4 read-address sequencer.
// Holds the FSM state encoding and the 4 KiB boundary arithmetic.
package finn_rtl_krnl_read_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } seq_state_e;

    localparam int unsigned K_4K_BYTES = 4096;

    // Beats of size 2**b_log2 left before the next 4 KiB boundary.
    function automatic logic [12:0] beats_to_4k(
        input logic [11:0] a_lo,
        input int unsigned b_log2
    );
        logic [12:0] room;
        room = 13'(K_4K_BYTES) - {1'b0, a_lo};
        return room >> b_log2;
    endfunction

endpackage

// File: rtl/finn_rtl_krnl_read_sequencer_if.sv
// AR request and R-monitor bundle between the sequencer and m_axi.
// The master side issues addresses; the slave side answers them.
interface finn_rtl_krnl_read_sequencer_if #(
    parameter int C_ADDR_WIDTH = 64
);
    logic                    arvalid;
    logic                    arready;
    logic [C_ADDR_WIDTH-1:0] araddr;
    logic [7:0]              arlen;
    logic                    r_beat;
    logic                    r_last;

    modport master (
        output arvalid, araddr, arlen,
        input  arready, r_beat, r_last
    );

    modport slave (
        input  arvalid, araddr, arlen,
        output arready, r_beat, r_last
    );
endinterface

// File: rtl/finn_rtl_krnl_example_counter.sv
// Saturating up/down counter used to track outstanding AR bursts.
// Exposes the post-update value so callers can act in the same edge.
module finn_rtl_krnl_example_counter #(
    parameter int C_WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               incr,
    input  logic               decr,
    output logic [C_WIDTH-1:0] count_next,
    output logic               is_zero
);

    logic [C_WIDTH-1:0] count_q;

    // next value: simultaneous incr/decr cancel, no wrap either way
    always_comb begin
        count_next = count_q;
        if (incr && !decr && count_q != '1) begin
            count_next = count_q + C_WIDTH'(1);
        end else if (decr && !incr && count_q != '0) begin
            count_next = count_q - C_WIDTH'(1);
        end
    end

    // zero after this cycle's update
    assign is_zero = (count_next == '0);

    // count register
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_next;
        end
    end

endmodule

// File: rtl/finn_rtl_krnl_read_sequencer.sv
// AXI4 read-address sequencer: splits N beats into AR bursts under a credit limit.
// Optional 4 KiB burst splitting is enabled by FINN_KRNL_READ_SEQ_4K_SPLIT_EN.
import finn_rtl_krnl_read_seq_pkg::*;

module finn_rtl_krnl_read_sequencer #(
    parameter int C_ADDR_WIDTH      = 64,
    parameter int C_DATA_WIDTH      = 512,
    parameter int C_LEN_WIDTH       = 32,
    parameter int C_MAX_BURST       = 64,
    parameter int C_MAX_OUTSTANDING = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ctrl_start,
    input  logic [C_ADDR_WIDTH-1:0] ctrl_addr,
    input  logic [C_LEN_WIDTH-1:0]  ctrl_xfer_beats,
    output logic                    ctrl_idle,
    output logic                    ctrl_done,
    finn_rtl_krnl_read_sequencer_if.master m_axi
);

    localparam int B_LOG2 = $clog2(C_DATA_WIDTH / 8);
    localparam int CNT_W  = $clog2(C_MAX_OUTSTANDING + 1);

    seq_state_e              state;
    logic                    arvalid_q;
    logic [C_ADDR_WIDTH-1:0] araddr_q;
    logic [7:0]              arlen_q;
    logic [8:0]              burst_q;
    logic [C_ADDR_WIDTH-1:0] next_addr;
    logic [C_LEN_WIDTH-1:0]  remaining;
    logic [C_LEN_WIDTH-1:0]  xfer_q;
    logic [C_LEN_WIDTH-1:0]  beat_cnt;

    logic                    hs;
    logic                    rlast_hit;
    logic                    cnt_clr;
    logic                    cnt_zero;
    logic [CNT_W-1:0]        out_next;
    logic [C_LEN_WIDTH-1:0]  rem_n;
    logic [C_ADDR_WIDTH-1:0] addr_n;
    logic [C_LEN_WIDTH-1:0]  beat_next;
    logic [8:0]              burst_start;
    logic [8:0]              burst_next;
    logic                    issue_ok;
    logic                    drain_ok;

    function automatic logic [8:0] min_burst(
        input logic [C_LEN_WIDTH-1:0] rem
    );
        if (rem < C_LEN_WIDTH'(C_MAX_BURST)) begin
            return 9'(rem);
        end
        return 9'(C_MAX_BURST);
    endfunction

`ifdef FINN_KRNL_READ_SEQ_4K_SPLIT_EN
    function automatic logic [8:0] cap_4k(
        input logic [11:0] a_lo,
        input logic [8:0]  b
    );
        logic [12:0] room;
        room = beats_to_4k(a_lo, B_LOG2);
        return (room < {4'd0, b}) ? room[8:0] : b;
    endfunction
`endif

    assign m_axi.arvalid = arvalid_q;
    assign m_axi.araddr  = araddr_q;
    assign m_axi.arlen   = arlen_q;

    // handshake terms and the view of state after this edge
    assign hs        = arvalid_q & m_axi.arready;
    assign rlast_hit = m_axi.r_beat & m_axi.r_last;
    assign cnt_clr   = rst | (state == S_IDLE);
    assign rem_n     = hs ? remaining - C_LEN_WIDTH'(burst_q) : remaining;
    assign addr_n    = hs ? araddr_q + (C_ADDR_WIDTH'(burst_q) << B_LOG2)
                          : next_addr;
    assign beat_next = beat_cnt + C_LEN_WIDTH'(m_axi.r_beat);

    // burst size for the first request and for every follow-up
    always_comb begin
        burst_start = min_burst(ctrl_xfer_beats);
        burst_next  = min_burst(rem_n);
`ifdef FINN_KRNL_READ_SEQ_4K_SPLIT_EN
        burst_start = cap_4k(ctrl_addr[11:0], burst_start);
        burst_next  = cap_4k(addr_n[11:0], burst_next);
`endif
    end

    assign issue_ok = (state == S_ISSUE) && (!arvalid_q || hs)
                   && (rem_n != '0)
                   && (out_next < CNT_W'(C_MAX_OUTSTANDING));
    assign drain_ok = cnt_zero && (beat_next == xfer_q);

    finn_rtl_krnl_example_counter #(
        .C_WIDTH (CNT_W)
    ) u_outstanding (
        .clk        (clk),
        .rst        (cnt_clr),
        .incr       (hs),
        .decr       (rlast_hit),
        .count_next (out_next),
        .is_zero    (cnt_zero)
    );

    // control FSM with registered AR and control outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ctrl_idle <= 1'b1;
            ctrl_done <= 1'b0;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            burst_q   <= '0;
            next_addr <= '0;
            remaining <= '0;
            xfer_q    <= '0;
            beat_cnt  <= '0;
        end else begin
            ctrl_done <= 1'b0;
            if (state != S_IDLE && m_axi.r_beat) begin
                beat_cnt <= beat_next;
            end
            unique case (state)
                S_IDLE: begin
                    if (ctrl_start) begin
                        xfer_q    <= ctrl_xfer_beats;
                        beat_cnt  <= '0;
                        ctrl_idle <= 1'b0;
                        if (ctrl_xfer_beats == '0) begin
                            state     <= S_DONE;
                            ctrl_done <= 1'b1;
                        end else begin
                            state     <= S_ISSUE;
                            remaining <= ctrl_xfer_beats;
                            next_addr <= ctrl_addr;
                            arvalid_q <= 1'b1;
                            araddr_q  <= ctrl_addr;
                            arlen_q   <= 8'(burst_start - 9'd1);
                            burst_q   <= burst_start;
                        end
                    end
                end
                S_ISSUE: begin
                    remaining <= rem_n;
                    next_addr <= addr_n;
                    if (hs) begin
                        arvalid_q <= 1'b0;
                    end
                    if (issue_ok) begin
                        arvalid_q <= 1'b1;
                        araddr_q  <= addr_n;
                        arlen_q   <= 8'(burst_next - 9'd1);
                        burst_q   <= burst_next;
                    end
                    if (hs && rem_n == '0) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (drain_ok) begin
                        state     <= S_DONE;
                        ctrl_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    ctrl_idle <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_finn_rtl_krnl_read_sequencer.sv
// Directed bench for the read-address sequencer (64 B beats, 64-beat bursts,
// two outstanding bursts); the 4 KiB case runs with FINN_KRNL_READ_SEQ_4K_SPLIT_EN.
module tb_finn_rtl_krnl_read_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        ctrl_start;
    logic [63:0] ctrl_addr;
    logic [31:0] ctrl_xfer_beats;
    logic        ctrl_idle;
    logic        ctrl_done;

    int total = 0;
    int bad   = 0;

    logic [63:0] ar_addr_q[$];
    int          ar_len_q[$];
    int          rq[$];
    int          beats_sent;
    bit          r_en;

    finn_rtl_krnl_read_sequencer_if #(.C_ADDR_WIDTH(64)) m_axi ();

    finn_rtl_krnl_read_sequencer #(
        .C_ADDR_WIDTH      (64),
        .C_DATA_WIDTH      (512),
        .C_LEN_WIDTH       (32),
        .C_MAX_BURST       (64),
        .C_MAX_OUTSTANDING (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ctrl_start      (ctrl_start),
        .ctrl_addr       (ctrl_addr),
        .ctrl_xfer_beats (ctrl_xfer_beats),
        .ctrl_idle       (ctrl_idle),
        .ctrl_done       (ctrl_done),
        .m_axi           (m_axi)
    );

    always #5 clk = ~clk;

    // log every AR handshake and queue its R burst
    always @(posedge clk) begin
        if (!rst && m_axi.arvalid && m_axi.arready) begin
            ar_addr_q.push_back(m_axi.araddr);
            ar_len_q.push_back(int'(m_axi.arlen));
            rq.push_back(int'(m_axi.arlen) + 1);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resp_step();
        m_axi.r_beat = 1'b0;
        m_axi.r_last = 1'b0;
        if (r_en && rq.size() > 0) begin
            m_axi.r_beat = 1'b1;
            beats_sent++;
            rq[0] = rq[0] - 1;
            if (rq[0] == 0) begin
                m_axi.r_last = 1'b1;
                void'(rq.pop_front());
            end
        end
    endtask

    task automatic do_start(input logic [63:0] a, input int n);
        ar_addr_q.delete();
        ar_len_q.delete();
        beats_sent      = 0;
        ctrl_start      = 1'b1;
        ctrl_addr       = a;
        ctrl_xfer_beats = 32'(n);
        tick();
        ctrl_start = 1'b0;
    endtask

    function automatic int issued_beats();
        int s = 0;
        foreach (ar_len_q[i]) s += ar_len_q[i] + 1;
        return s;
    endfunction

    // run responses until done; check AR hold and done timing
    task automatic run_xfer(input int exp_beats, input bit stall,
                            input int budget);
        bit          got_done = 0;
        bit          fin;
        bit          held;
        logic [63:0] h_addr;
        logic [7:0]  h_len;
        for (int cyc = 0; cyc < budget && !got_done; cyc++) begin
            m_axi.arready = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
            resp_step();
            fin    = m_axi.r_last && (beats_sent == exp_beats);
            held   = m_axi.arvalid && !m_axi.arready;
            h_addr = m_axi.araddr;
            h_len  = m_axi.arlen;
            tick();
            if (held) begin
                chk("ar_hold_addr", m_axi.araddr, h_addr);
                chk("ar_hold_len", 64'(m_axi.arlen), 64'(h_len));
            end
            if (ctrl_done) begin
                got_done = 1;
                chk("done_after_last", 64'(fin), 64'd1);
                chk("idle_at_done", 64'(ctrl_idle), 64'd0);
            end
        end
        m_axi.r_beat  = 1'b0;
        m_axi.r_last  = 1'b0;
        m_axi.arready = 1'b1;
        chk("done_seen", 64'(got_done), 64'd1);
        chk("issued_beats", 64'(issued_beats()), 64'(exp_beats));
        tick();
        chk("done_one_cycle", 64'(ctrl_done), 64'd0);
        chk("idle_after_done", 64'(ctrl_idle), 64'd1);
    endtask

    initial begin
        rst             = 1'b1;
        ctrl_start      = 1'b0;
        ctrl_addr       = '0;
        ctrl_xfer_beats = '0;
        m_axi.arready   = 1'b1;
        m_axi.r_beat    = 1'b0;
        m_axi.r_last    = 1'b0;
        r_en            = 1'b1;
        beats_sent      = 0;
        repeat (3) tick();
        chk("rst_idle", 64'(ctrl_idle), 64'd1);
        chk("rst_done", 64'(ctrl_done), 64'd0);
        chk("rst_arvalid", 64'(m_axi.arvalid), 64'd0);
        chk("rst_araddr", m_axi.araddr, 64'h0);
        chk("rst_arlen", 64'(m_axi.arlen), 64'd0);
        rst = 1'b0;
        tick();

        // 200 beats from 0x1000: four bursts, back-to-back start
        do_start(64'h1000, 200);
        chk("a_first_valid", 64'(m_axi.arvalid), 64'd1);
        chk("a_first_addr", m_axi.araddr, 64'h1000);
        chk("a_first_len", 64'(m_axi.arlen), 64'd63);
        m_axi.arready = 1'b1;
        tick();
        chk("a_b2b_valid", 64'(m_axi.arvalid), 64'd1);
        chk("a_b2b_addr", m_axi.araddr, 64'h2000);
        run_xfer(200, 1'b0, 2000);
        chk("a_ar_count", 64'(ar_addr_q.size()), 64'd4);
        if (ar_addr_q.size() == 4) begin
            chk("a_ar3_addr", ar_addr_q[2], 64'h3000);
            chk("a_ar3_len", 64'(ar_len_q[2]), 64'd63);
            chk("a_ar4_addr", ar_addr_q[3], 64'h4000);
            chk("a_ar4_len", 64'(ar_len_q[3]), 64'd7);
        end

        // zero-length start: done in the next cycle, no AR
        do_start(64'h5000, 0);
        chk("z_done", 64'(ctrl_done), 64'd1);
        chk("z_arvalid", 64'(m_axi.arvalid), 64'd0);
        tick();
        chk("z_done_clear", 64'(ctrl_done), 64'd0);
        chk("z_idle", 64'(ctrl_idle), 64'd1);
        chk("z_no_ar", 64'(ar_addr_q.size()), 64'd0);

        // credit limit: two ARs, then one more per freed credit
        r_en = 1'b0;
        do_start(64'h0, 256);
        repeat (8) tick();
        chk("c_ar_count", 64'(ar_addr_q.size()), 64'd2);
        chk("c_arvalid_low", 64'(m_axi.arvalid), 64'd0);
        r_en = 1'b1;
        for (int i = 0; i < 64; i++) begin
            resp_step();
            tick();
            if (i == 62) chk("c_wait_credit", 64'(m_axi.arvalid), 64'd0);
        end
        chk("c_reissue_valid", 64'(m_axi.arvalid), 64'd1);
        chk("c_reissue_addr", m_axi.araddr, 64'h2000);
        m_axi.r_beat = 1'b0;
        m_axi.r_last = 1'b0;
        tick();
        chk("c_ar_count3", 64'(ar_addr_q.size()), 64'd3);
        chk("c_arvalid_low2", 64'(m_axi.arvalid), 64'd0);
        run_xfer(256, 1'b0, 2000);

        // random AR stalls with a short tail burst
        do_start(64'h10000, 300);
        run_xfer(300, 1'b1, 4000);
        chk("s_ar_count", 64'(ar_addr_q.size()), 64'd5);
        if (ar_addr_q.size() == 5) begin
            chk("s_tail_addr", ar_addr_q[4], 64'h14000);
            chk("s_tail_len", 64'(ar_len_q[4]), 64'd43);
        end

`ifdef FINN_KRNL_READ_SEQ_4K_SPLIT_EN
        // a burst that would cross 0x1000 is split there
        do_start(64'h0FC0, 64);
        run_xfer(64, 1'b0, 1000);
        chk("k_ar_count", 64'(ar_addr_q.size()), 64'd2);
        if (ar_addr_q.size() == 2) begin
            chk("k_ar1_addr", ar_addr_q[0], 64'h0FC0);
            chk("k_ar1_len", 64'(ar_len_q[0]), 64'd0);
            chk("k_ar2_addr", ar_addr_q[1], 64'h1000);
            chk("k_ar2_len", 64'(ar_len_q[1]), 64'd62);
        end
`endif

        // reset in DRAIN, stale beats while idle, then a clean run
        r_en = 1'b0;
        do_start(64'h0, 128);
        repeat (4) tick();
        chk("r_ar_count", 64'(ar_addr_q.size()), 64'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("r_idle", 64'(ctrl_idle), 64'd1);
        chk("r_arvalid", 64'(m_axi.arvalid), 64'd0);
        chk("r_done", 64'(ctrl_done), 64'd0);
        r_en = 1'b1;
        for (int i = 0; i < 200 && rq.size() > 0; i++) begin
            resp_step();
            tick();
        end
        m_axi.r_beat = 1'b0;
        m_axi.r_last = 1'b0;
        tick();
        chk("r_stale_idle", 64'(ctrl_idle), 64'd1);
        chk("r_stale_done", 64'(ctrl_done), 64'd0);
        chk("r_stale_arvalid", 64'(m_axi.arvalid), 64'd0);
        do_start(64'h8000, 64);
        chk("r_new_addr", m_axi.araddr, 64'h8000);
        run_xfer(64, 1'b0, 1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
